// File: rtl/statistics_update_arbiter.sv
// statistics_update_arbiter: round-robin arbiter that merges same-address requests
// into paced read-modify-write updates for an increment-mode statistics RAM.
//   clk_i        clock, all logic on posedge
//   reset_i      asynchronous active-high reset
//   req_valid_i  per-requester pending flag
//   req_ready_o  per-requester accept (transfer = valid & ready)
//   req_addr_i   packed requester addresses, req i at [i*AW +: AW]
//   req_inc_i    packed requester increments, req i at [i*IW +: IW]
//   stat_addr_o  statistics address
//   stat_we_o    statistics write enable, never high on consecutive cycles
//   stat_din_o   statistics increment value
//   upd_count_o  number of issued updates, wrapping
module statistics_update_arbiter #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_MATCH_ADDR_WIDTH = 10,
    parameter int C_INC_WIDTH        = 16,
    parameter int C_COUNTER_WIDTH    = 64
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [C_NUM_REQ-1:0]                     req_valid_i,
    output logic [C_NUM_REQ-1:0]                     req_ready_o,
    input  logic [C_NUM_REQ*C_MATCH_ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [C_NUM_REQ*C_INC_WIDTH-1:0]         req_inc_i,
    output logic [C_MATCH_ADDR_WIDTH-1:0]            stat_addr_o,
    output logic                                     stat_we_o,
    output logic [C_COUNTER_WIDTH-1:0]               stat_din_o,
    output logic [31:0]                              upd_count_o
);
    localparam int AW = C_MATCH_ADDR_WIDTH;
    localparam int IW = C_INC_WIDTH;
    localparam int CW = C_COUNTER_WIDTH;
    localparam int PW = $clog2(C_NUM_REQ);
    localparam int SW = IW + PW;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d, win, cand;
    logic [AW-1:0]   addr_q, addr_d, win_addr;
    logic [CW-1:0]   din_q, din_d;
    logic [31:0]     upd_count_q, upd_count_d;
    logic            we_q, we_d, found;
    logic [C_NUM_REQ-1:0] merge;
    logic [SW-1:0]   sum;

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            cand = PW'((int'(rr_q) + k) % C_NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Every valid requester sharing the winner's address rides along in the same update.
    always_comb begin
        win_addr = '0;
        merge    = '0;
        sum      = '0;
        for (int i = 0; i < C_NUM_REQ; i++)
            if (PW'(i) == win) win_addr = req_addr_i[i*AW +: AW];
        for (int i = 0; i < C_NUM_REQ; i++) begin
            merge[i] = req_valid_i[i] && (req_addr_i[i*AW +: AW] == win_addr);
            sum      = sum + (merge[i] ? SW'(req_inc_i[i*IW +: IW]) : SW'(0));
        end
    end

    assign req_ready_o = (state_q == IDLE) ? merge : '0;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        upd_count_d = upd_count_q;
        if (state_q == IDLE && found) begin
            state_d = HOLD;
            we_d    = 1'b1;
            addr_d  = win_addr;
            din_d   = CW'(sum);
            rr_d    = (win == PW'(C_NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (state_q == HOLD) begin
            state_d     = IDLE;
            upd_count_d = upd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            upd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            upd_count_q <= upd_count_d;
        end
    end

    assign stat_addr_o = addr_q;
    assign stat_we_o   = we_q;
    assign stat_din_o  = din_q;
    assign upd_count_o = upd_count_q;
endmodule

// File: tb/tb_statistics_update_arbiter.sv
// tb_statistics_update_arbiter: directed and random checks of the arbiter against a transaction-level model.
module tb_statistics_update_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int IW = 16;
    localparam int CW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid, ready;
    logic [N*AW-1:0] addr_bus;
    logic [N*IW-1:0] inc_bus;
    logic [AW-1:0]   s_addr;
    logic            s_we;
    logic [CW-1:0]   s_din;
    logic [31:0]     cnt;

    logic [N-1:0]    v = '0;
    logic [AW-1:0]   a [N];
    logic [IW-1:0]   inc [N];

    int checks = 0;
    int errors = 0;

    int            m_rr;
    bit            m_busy, m_we;
    logic [AW-1:0] m_addr;
    logic [CW-1:0] m_din;
    logic [31:0]   m_cnt;
    logic [CW-1:0] exp_tot [int];
    logic [CW-1:0] ram [int];
    bit            prev_we;

    logic [N-1:0]  o_ready;
    logic          o_we;
    logic [CW-1:0] o_din;

    statistics_update_arbiter #(
        .C_NUM_REQ(N), .C_MATCH_ADDR_WIDTH(AW), .C_INC_WIDTH(IW), .C_COUNTER_WIDTH(CW)
    ) dut (
        .clk_i(clk), .reset_i(rst), .req_valid_i(valid), .req_ready_o(ready),
        .req_addr_i(addr_bus), .req_inc_i(inc_bus), .stat_addr_o(s_addr),
        .stat_we_o(s_we), .stat_din_o(s_din), .upd_count_o(cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        valid = v;
        for (int i = 0; i < N; i++) begin
            addr_bus[i*AW +: AW] = a[i];
            inc_bus[i*IW +: IW]  = inc[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_busy = 0; m_we = 0; m_addr = '0; m_din = '0; m_cnt = '0; prev_we = 0;
        exp_tot.delete();
        ram.delete();
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [IW-1:0] in);
        a[i] = ad; inc[i] = in; v[i] = 1'b1;
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge, retire accepted requests.
    task automatic step();
        int w = -1;
        logic [N-1:0] m = '0;
        logic [CW-1:0] s = '0;
        int k;
        if (!m_busy)
            for (int q = 0; q < N; q++)
                if (w < 0 && v[(m_rr + q) % N]) w = (m_rr + q) % N;
        if (w >= 0)
            for (int i = 0; i < N; i++)
                if (v[i] && a[i] == a[w]) begin m[i] = 1'b1; s += CW'(inc[i]); end
        @(negedge clk);
        o_ready = ready; o_we = s_we; o_din = s_din;
        chk("ready", ready, m);
        chk("we", s_we, m_we);
        chk("we_gap", prev_we & s_we, 0);
        chk("addr", s_addr, m_addr);
        chk("din", s_din, m_din);
        chk("cnt", cnt, m_cnt);
        if (s_we) begin
            k = int'(s_addr);
            ram[k] = (ram.exists(k) ? ram[k] : '0) + s_din;
        end
        prev_we = s_we;
        if (w >= 0) begin
            for (int i = 0; i < N; i++)
                if (m[i]) begin
                    k = int'(a[i]);
                    exp_tot[k] = (exp_tot.exists(k) ? exp_tot[k] : '0) + CW'(inc[i]);
                end
            m_we = 1; m_addr = a[w]; m_din = s; m_rr = (w + 1) % N; m_busy = 1;
        end else if (m_busy) begin
            m_we = 0; m_cnt++; m_busy = 0;
        end
        @(posedge clk);
        #1;
        v = v & ~m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v = '0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin a[i] = '0; inc[i] = '0; end
        model_reset();
        repeat (2) @(posedge clk);
        step();
        rst = 1'b0;

        // single requester
        set_req(0, 10'd5, 16'd64);
        step(); chk("t1_ready", o_ready, 4'b0001);
        step(); chk("t1_we", o_we, 1); chk("t1_din", o_din, 64); chk("t1_ready_hold", o_ready, 0);
        step(); chk("t1_we_off", o_we, 0);

        // merge of req1/req3 with rr_ptr=1, req2 follows two cycles later
        set_req(1, 10'd7, 16'd10); set_req(3, 10'd7, 16'd20); set_req(2, 10'd9, 16'd1);
        step(); chk("t3_ready", o_ready, 4'b1010);
        step(); chk("t3_din", o_din, 30);
        step(); chk("t3_ready2", o_ready, 4'b0100);
        step(); chk("t3_din2", o_din, 1);
        step();

        // reset during HOLD drops stat_we without a clock edge
        set_req(1, 10'd3, 16'd3);
        step();
        #2 rst = 1'b1;
        #1 chk("t5_we_async", s_we, 0);
        v = '0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 10'd5, 16'd64);
        step(); chk("t5_ready", o_ready, 4'b0001);
        step(); step();

        // continuous requests from all four: strict rotation, one grant every 2 cycles
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 16'd1);
        for (int s = 0; s < 10; s++) begin
            step();
            chk("t2_grant", o_ready, (s % 2 == 0) ? (4'b0001 << ((s / 2) % 4)) : 4'b0000);
            v = '1;
        end
        v = '0;
        step();

        // full merge at maximum increment
        for (int i = 0; i < N; i++) set_req(i, 10'd0, 16'hFFFF);
        step(); chk("t4_ready", o_ready, 4'b1111);
        step(); chk("t4_din", o_din, 64'h3FFFC);
        step();

        // counter wrap and accumulation into the attached statistics RAM
        force dut.upd_count_q = 32'hFFFF_FFFF;
        #1 release dut.upd_count_q;
        m_cnt = 32'hFFFF_FFFF;
        ram.delete();
        exp_tot.delete();
        set_req(0, 10'd2, 16'd5); set_req(2, 10'd2, 16'd6);
        step(); chk("t6_ready", o_ready, 4'b0101);
        step(); chk("t6_din", o_din, 11);
        chk("t6_wrap", cnt, 0);
        set_req(3, 10'd2, 16'd7);
        step(); step(); step();
        chk("t6_ram2", ram.exists(2) ? ram[2] : '0, 18);

        // random traffic with frequent address collisions
        ram.delete();
        exp_tot.delete();
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++)
                if (!v[i] && $urandom_range(0, 2) != 0) set_req(i, AW'($urandom_range(0, 3)), IW'($urandom));
            step();
        end
        for (int s = 0; s < 40 && (v != '0 || m_busy); s++) step();
        chk("drain", v, 0);
        step();
        chk("ram_keys", ram.num(), exp_tot.num());
        foreach (exp_tot[k]) chk("ram_total", ram.exists(k) ? ram[k] : '0, exp_tot[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
